// File: rtl/mul4x3_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul4x3_share_arbiter
//
// Shares one combinational 4x3 unsigned multiplier between two requesters.
// The winner's operands are captured into c_r/d_r when the block is idle. The
// multiplier is driven from those registers. The product is registered into m,
// and a one-cycle ack goes back to the winner. One product is returned every
// three cycles.
//
// Optional feature (compile-time macro):
//   MUL4X3_ARB_RR_EN  defined   -> round-robin on a tie (the requester that was
//                                  not served last wins)
//                     undefined -> fixed priority, requester 0 wins a tie
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req0      in   1  request from requester 0 (held until ack0)
//   c0        in   4  multiplicand from requester 0
//   d0        in   3  multiplier operand from requester 0
//   req1      in   1  request from requester 1 (held until ack1)
//   c1        in   4  multiplicand from requester 1
//   d1        in   3  multiplier operand from requester 1
//   ack0      out  1  one-cycle pulse; m holds requester 0's product
//   ack1      out  1  one-cycle pulse; m holds requester 1's product
//   m         out  7  registered product, held until the next capture
//   busy      out  1  high while in CALC or ACK
//   grant_id  out  1  requester currently or most recently served
// -----------------------------------------------------------------------------

module multiplier_4x3 (
    input  logic [3:0] c,
    input  logic [2:0] d,
    output logic [6:0] m
);
    // 15 * 7 = 105 is the largest product, so 7 bits never overflow.
    assign m = c * d;
endmodule

module mul4x3_share_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] c0,
    input  logic [2:0] d0,
    input  logic       req1,
    input  logic [3:0] c1,
    input  logic [2:0] d1,
    output logic       ack0,
    output logic       ack1,
    output logic [6:0] m,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       any_req;
    logic       winner;
    logic       last_grant;
    logic [3:0] c_r;
    logic [2:0] d_r;
    logic [6:0] m_mul;

    assign any_req = req0 | req1;

    // Winner selection. The result is only used when any_req is high. When a
    // single request is pending, that requester wins.
`ifdef MUL4X3_ARB_RR_EN
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = req1;
        end
    end
`else
    always_comb begin
        winner = 1'b0;
        if (!req0) begin
            winner = req1;
        end
    end

    // last_grant is still tracked in this build, but it does not steer
    // selection.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    multiplier_4x3 u_mul (
        .c (c_r),
        .d (d_r),
        .m (m_mul)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CALC;
            CALC:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. busy comes straight from the state register, so there is
    // no path from the inputs to this output.
    always_comb begin
        busy = (state != IDLE);
    end

    // Capture stage (IDLE): latch the winner's operands and the grant.
    // Product stage (CALC): register the product and raise the winner's ack.
    // The ack is high only while in ACK, so it always clears after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r        <= '0;
            d_r        <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            m          <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        c_r        <= winner ? c1 : c0;
                        d_r        <= winner ? d1 : d0;
                        grant_id   <= winner;
                        last_grant <= winner;
                    end
                end
                CALC: begin
                    m    <= m_mul;
                    ack0 <= ~grant_id;
                    ack1 <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul4x3_share_arbiter.md
# mul4x3_share_arbiter

Sequential arbiter and controller that shares one combinational 4x3 unsigned multiplier (`multiplier_4x3`: `M = C*D`, 4-bit × 3-bit → 7-bit) between two requesters. It captures the winning requester's operands into registers, drives the multiplier from those registers, and registers the 7-bit product. It then returns the product with a one-cycle acknowledge. It sits between two client blocks and a single `multiplier_4x3` instance, which it instantiates internally.

## Interface
- Parameters: none. Widths are fixed by `multiplier_4x3`: C is 4 bits, D is 3 bits, M is 7 bits.
- Ports:
  - `clk` — in, 1, sole clock; rising-edge.
  - `rst_n` — in, 1, asynchronous active-low reset.
  - `req0` — in, 1, request from requester 0; held high until `ack0`.
  - `c0` — in, 4, multiplicand from requester 0; stable while `req0` is high.
  - `d0` — in, 3, multiplier operand from requester 0.
  - `req1` — in, 1, request from requester 1.
  - `c1` — in, 4, multiplicand from requester 1.
  - `d1` — in, 3, multiplier operand from requester 1.
  - `ack0` — out, 1, one-cycle pulse; `m` holds requester 0's product.
  - `ack1` — out, 1, one-cycle pulse; `m` holds requester 1's product.
  - `m` — out, 7, registered product; valid during ack and held until the next capture.
  - `busy` — out, 1, high in CALC and ACK.
  - `grant_id` — out, 1, index of the requester currently or most recently served.

## Operation
- The FSM has three states: IDLE, CALC and ACK.
  - IDLE:
    - If no request is pending, stay in IDLE.
    - If a request is pending, pick a winner.
    - Register `c_r`/`d_r` from the winner's operands, set `grant_id` and `last_grant` to the winner, and go to CALC.
  - CALC: `multiplier_4x3` is driven by `c_r`/`d_r`. `m <= M`, the winner's ack register is set to 1, and the FSM goes to ACK.
  - ACK: the ack is high this cycle. At the next edge the ack clears and the FSM returns to IDLE.
- Arithmetic is unsigned with no overflow: the maximum product is 15 × 7 = 105, which fits in 7 bits.
- Arbitration applies only when both `req0` and `req1` are high in IDLE. A single request always wins.
- Requests cannot be cancelled:
  - Once captured, the operation completes and the ack is issued even if the request drops during CALC.
  - Operands are sampled only at the IDLE capture edge, so changes afterwards are ignored.
- A request still high in the IDLE cycle after its ack is treated as a new request.
- `ack0` and `ack1` are never high together. Only the ack indicated by `grant_id` can be high.
- Reset values:
  - State is IDLE.
  - `ack0`, `ack1`, `busy`, `m`, `grant_id`, `c_r` and `d_r` are all 0.
  - `last_grant` is 1, so requester 0 wins the first tie.
- Reset mid-operation (`rst_n` low in CALC or ACK) returns the block to IDLE with all outputs 0. The pending ack is never issued, and requesters must re-request.

## Timing
- Edge k: in IDLE, a request is sampled high and the operands are captured.
- Edge k+1: `m` is updated and the ack is set. The ack and the new `m` are visible during cycle k+1 to k+2.
- Edge k+2: the ack clears and the FSM is in IDLE. A new capture can occur at edge k+3.
- Throughput is one product per 3 cycles.
- `busy` rises after edge k and falls after edge k+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MUL4X3_ARB_RR_EN` defined:
  - Round-robin arbitration: on a tie, the requester `!last_grant` wins.
  - With continuous requests from both sides, service alternates 0, 1, 0, 1, …
- `MUL4X3_ARB_RR_EN` undefined:
  - Fixed priority: requester 0 always wins a tie.
  - `last_grant` is still maintained but does not affect selection.
  - Requester 1 can starve while `req0` stays high.

## Test plan
- Reset: drive `rst_n` low, then release. All outputs are 0 and `busy` is 0. With `req0 = req1 = 0` for 10 cycles, no ack occurs.
- Single request: `req0 = 1`, `c0 = 4'b0110`, `d0 = 3'b111` sampled at edge k. `ack0` is high exactly during k+1 to k+2, `m = 42`, `grant_id = 0`, `ack1` stays 0.
- Requester 1 only: `c1 = 4'b1010`, `d1 = 3'b101` gives `m = 50` and `ack1` after 2 cycles, `grant_id = 1`. Corner operands `0×0 → 0`, `1×3 → 3` and `15×7 → 105` each produce the correct `m`.
- Contention:
  - Operands: `req0` and `req1` held high with requester 0 at 15×7 (105) and requester 1 at 13×2 (26).
  - With `MUL4X3_ARB_RR_EN`: acks alternate `ack0`/`ack1`, giving `m` = 105, 26, 105, …, one ack every 3 cycles.
  - Without it: only `ack0` occurs.
- Operand change and dropped request: after capture of 1×3, change `c0`/`d0` and drop `req0` in CALC. `ack0` still fires with `m = 3`.
- Reset mid-op: assert `rst_n` low during CALC. No ack follows, `m = 0`, and after release a fresh request completes normally.
